// File: rtl/pwm_generator.sv
// pwm_generator: shared 8-bit PWM driving 16 registered pads, define PWM_SHADOW_EN to latch duty only at period wrap
module pwm_generator #(
  parameter int PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d, duty_active;
  logic [15:0] pins_q, pins_d;
  logic period_start_q, period_start_d, tick, wrap, pwm_level;
`ifdef PWM_SHADOW_EN
  logic [7:0] duty_active_q, duty_active_d;
`endif
  always_comb begin
    tick = pre_cnt_q == PW'(PRESCALE - 1);
    wrap = tick && pwm_cnt_q == 8'hFF;
    pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
    pwm_cnt_d = pwm_cnt_q + {7'd0, tick};
`ifdef PWM_SHADOW_EN
    duty_active_d = wrap ? pwm_duty_cycle : duty_active_q;
    duty_active = duty_active_q;
`else
    duty_active = pwm_duty_cycle;
`endif
    pwm_level = duty_active == 8'hFF || pwm_cnt_q < duty_active;
    pins_d = {en_reg_out_15_8, en_reg_out_7_0} & (~{en_reg_pwm_15_8, en_reg_pwm_7_0} | {16{pwm_level}});
    period_start_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      pins_q <= '0;
      period_start_q <= 1'b0;
`ifdef PWM_SHADOW_EN
      duty_active_q <= '0;
`endif
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      pins_q <= pins_d;
      period_start_q <= period_start_d;
`ifdef PWM_SHADOW_EN
      duty_active_q <= duty_active_d;
`endif
    end
  end
  assign uo_out = pins_q[7:0];
  assign uio_out = pins_q[15:8];
  assign period_start = period_start_q;
endmodule
